// File: rtl/reg_bank.sv
// Parametrised register bank: one write port, two registered read ports (A, B),
// write-to-read bypass, synchronous clear and an optional hard-wired zero register.
module reg_bank #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter bit ZERO_REG = 1'b0,
    parameter int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
    logic             wr_ok;

    // An address is live when it maps to a real register that is not hard-wired zero.
    function automatic logic addr_live(input logic [AW-1:0] addr);
        return ({1'b0, addr} < DEPTH_L) && !(ZERO_REG && (addr == '0));
    endfunction

    assign wr_ok = we && addr_live(waddr);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch is inferred.
        mem_d     = mem_q;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            rdata_a_d = '0;
            rdata_b_d = '0;
        end else begin
            if (wr_ok) begin
                mem_d[waddr] = wdata;
            end
            // Reads sample mem_d, so an accepted same-edge write bypasses to the port.
            if (re_a) begin
                rdata_a_d = addr_live(raddr_a) ? mem_d[raddr_a] : '0;
            end
            if (re_b) begin
                rdata_b_d = addr_live(raddr_b) ? mem_d[raddr_b] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage array is reset too, since a read after reset must return 0.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            // NOTE: non-blocking assignments for all state so every flop sees pre-edge values.
            mem_q     <= mem_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: three configurations share one stimulus stream
// and are compared against a per-configuration array model of the register file.
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr, we, re_a, re_b;
    logic [2:0]  waddr, raddr_a, raddr_b;
    logic [15:0] wdata;
    logic [15:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1, rdata_a2, rdata_b2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_bank #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b0)) u_dut_base (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a0),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b0)
    );

    reg_bank #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b1)) u_dut_zero (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a1),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b1)
    );

    reg_bank #(.WIDTH(16), .DEPTH(6), .ZERO_REG(1'b0)) u_dut_d6 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a2),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b2)
    );

    // Reference model: one plain array per configuration plus the expected port values.
    int          cfg_depth [3] = '{8, 8, 6};
    bit          cfg_zero  [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] mdl_mem   [3][8];
    logic [15:0] exp_a     [3];
    logic [15:0] exp_b     [3];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 8; i++) mdl_mem[c][i] = 16'h0000;
            exp_a[c] = 16'h0000;
            exp_b[c] = 16'h0000;
        end
    endtask

    function automatic logic [15:0] model_peek(int c, int addr, bit wr_ok);
        if (addr >= cfg_depth[c] || (cfg_zero[c] && addr == 0)) return 16'h0000;
        if (wr_ok && addr == int'(waddr)) return wdata;
        return mdl_mem[c][addr];
    endfunction

    task automatic model_edge();
        bit ok;
        for (int c = 0; c < 3; c++) begin
            if (clr) begin
                for (int i = 0; i < 8; i++) mdl_mem[c][i] = 16'h0000;
                exp_a[c] = 16'h0000;
                exp_b[c] = 16'h0000;
            end else begin
                ok = we && (int'(waddr) < cfg_depth[c]) && !(cfg_zero[c] && waddr == 3'd0);
                if (re_a) exp_a[c] = model_peek(c, int'(raddr_a), ok);
                if (re_b) exp_b[c] = model_peek(c, int'(raddr_b), ok);
                if (ok) mdl_mem[c][waddr] = wdata;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/base_a"}, rdata_a0, exp_a[0]);
        check({tag, "/base_b"}, rdata_b0, exp_b[0]);
        check({tag, "/zero_a"}, rdata_a1, exp_a[1]);
        check({tag, "/zero_b"}, rdata_b1, exp_b[1]);
        check({tag, "/d6_a"},   rdata_a2, exp_a[2]);
        check({tag, "/d6_b"},   rdata_b2, exp_b[2]);
    endtask

    // Apply one cycle of inputs, advance the model on the edge, compare 1 time unit later.
    task automatic step(input bit c, input bit w, input logic [2:0] wa, input logic [15:0] wd,
                        input bit ea, input logic [2:0] aa, input bit eb, input logic [2:0] ab,
                        input string tag);
        clr = c; we = w; waddr = wa; wdata = wd;
        re_a = ea; raddr_a = aa; re_b = eb; raddr_b = ab;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        clr = 0; we = 0; waddr = 0; wdata = 0; re_a = 0; raddr_a = 0; re_b = 0; raddr_b = 0;
        rst_n = 1'b0;
        model_reset();
        #12;
        check_all("reset_init");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset abandons state: outputs clear asynchronously and r3 reads back 0.
        step(0, 1, 3'd3, 16'h1234, 0, 3'd0, 0, 3'd0, "t1_wr");
        step(0, 0, 3'd0, 16'h0000, 1, 3'd3, 1, 3'd3, "t1_rd");
        check("t1_pre_a", rdata_a0, 16'h1234);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t1_async");
        check("t1_async_lit", rdata_a0, 16'h0000);
        @(posedge clk);
        #1;
        check_all("t1_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 3'd0, 16'h0000, 1, 3'd3, 1, 3'd3, "t1_rd_after");
        check("t1_after_lit", rdata_a0, 16'h0000);

        // Write then read, then hold for three idle cycles.
        step(0, 1, 3'd5, 16'hBEEF, 0, 3'd0, 0, 3'd0, "t2_wr");
        step(0, 0, 3'd0, 16'h0000, 1, 3'd5, 0, 3'd0, "t2_rd");
        check("t2_rd_lit", rdata_a0, 16'hBEEF);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 3'd0, 16'h0000, 0, 3'd1, 0, 3'd0, "t2_hold");
            check("t2_hold_lit", rdata_a0, 16'hBEEF);
        end

        // Bypass on both ports in the same edge as the write.
        step(0, 1, 3'd2, 16'h00A5, 1, 3'd2, 1, 3'd2, "t3_byp");
        check("t3_byp_a", rdata_a0, 16'h00A5);
        check("t3_byp_b", rdata_b0, 16'h00A5);

        // Fill, then clear with a competing write and read.
        for (int i = 0; i < 8; i++)
            step(0, 1, 3'(i), 16'(16'h1111 * i), 1, 3'(i), 1, 3'(7 - i), "t4_fill");
        step(0, 0, 3'd0, 16'h0000, 1, 3'd7, 1, 3'd1, "t4_pre");
        check("t4_pre_lit", rdata_a0, 16'h7777);
        step(1, 1, 3'd1, 16'hFFFF, 1, 3'd1, 1, 3'd7, "t4_clr");
        check("t4_clr_lit", rdata_a0, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 3'd0, 16'h0000, 1, 3'(i), 1, 3'(i), "t4_rd");
            check("t4_rd_lit", rdata_a0, 16'h0000);
        end

        // Hard-wired zero register: plain and bypassed reads of r0 give 0.
        step(0, 1, 3'd4, 16'h4444, 0, 3'd0, 0, 3'd0, "t5_wr4");
        step(0, 1, 3'd0, 16'h5555, 1, 3'd4, 1, 3'd4, "t5_wr0");
        check("t5_r4_lit", rdata_a1, 16'h4444);
        step(0, 1, 3'd0, 16'h5555, 1, 3'd0, 1, 3'd4, "t5_byp0");
        check("t5_byp0_lit", rdata_a1, 16'h0000);
        check("t5_base_byp0_lit", rdata_a0, 16'h5555);
        step(0, 0, 3'd0, 16'h0000, 0, 3'd0, 1, 3'd0, "t5_rd0");
        check("t5_rd0_lit", rdata_b1, 16'h0000);

        // Out-of-range addresses on the six-entry bank.
        step(0, 1, 3'd3, 16'h3333, 1, 3'd3, 0, 3'd0, "t6_wr3");
        step(0, 1, 3'd7, 16'hABCD, 1, 3'd7, 1, 3'd6, "t6_wr7");
        check("t6_a7_lit", rdata_a2, 16'h0000);
        check("t6_b6_lit", rdata_b2, 16'h0000);
        for (int i = 0; i < 8; i++)
            step(0, 0, 3'd0, 16'h0000, 1, 3'(i), 1, 3'(7 - i), "t6_scan");

        // Randomized traffic with bypass bias and occasional clear.
        for (int n = 0; n < 800; n++) begin
            logic [2:0] wa, aa, ab;
            wa = 3'($urandom_range(0, 7));
            aa = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
            ab = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
            step(($urandom_range(0, 31) == 0), 1'($urandom), wa, 16'($urandom),
                 1'($urandom), aa, 1'($urandom), ab, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
